// File: rtl/smac_relu_pkg.sv
// Shared types and constants for the quantize/ReLU lane sequencing path.
// Reused by the top level that ties relu_out_packer.sel to quant_ReLU.sel.
package smac_relu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

endpackage

// File: rtl/relu_out_packer.sv
// Steps sel through four ReLU lanes, packs the captured values into one word,
// offers it downstream and counts words per layer.
module relu_out_packer
  import smac_relu_pkg::*;
#(
  parameter int  Pa      = 8,
  parameter int  N_WORDS = 16,
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [Pa-1:0]        relu_in,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  output logic [LANES*Pa-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 layer_done,
  output state_t               state_dbg
);

  state_t              r_state;
  logic [SEL_W-1:0]    r_lane;
  logic [LANES*Pa-1:0] r_data;
  logic [IDX_W-1:0]    r_word_idx;
  logic                r_layer_done;

  logic w_accept;
  logic w_last_word;

  // Handshake: a word transfers on any rising edge where out_valid && out_ready;
  // once out_valid rises, out_data and word_idx hold until that transfer or reset.
  assign w_accept    = (r_state == ST_HOLD) && out_ready;
  assign w_last_word = (r_word_idx == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_data       <= '0;
      r_word_idx   <= '0;
      r_layer_done <= 1'b0;
    end else begin
      r_layer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_lane <= '0;
          if (start) r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          r_data[int'(r_lane)*Pa +: Pa] <= relu_in;
          if (r_lane == SEL_W'(LANES - 1)) begin
            r_lane  <= '0;
            r_state <= ST_HOLD;
          end else begin
            r_lane <= r_lane + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_word_idx   <= w_last_word ? '0 : r_word_idx + 1'b1;
            r_layer_done <= w_last_word;
            r_lane       <= '0;
            r_state      <= start ? ST_SCAN : ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_lane  <= '0;
        end
      endcase
    end
  end

  // r_lane is held at zero outside SCAN, so sel comes straight from the register.
  assign sel        = r_lane;
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = (r_state == ST_HOLD);
  assign out_data   = r_data;
  assign word_idx   = r_word_idx;
  assign layer_done = r_layer_done;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_relu_out_packer.sv
// Directed bench for relu_out_packer with a combinational lane-value model on sel.
module tb_relu_out_packer;
  import smac_relu_pkg::*;

  localparam int Pa      = 8;
  localparam int N_WORDS = 2;
  localparam int IDX_W   = 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [Pa-1:0]     relu_in;
  logic [1:0]        sel;
  logic              busy;
  logic [4*Pa-1:0]   out_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  word_idx;
  logic              layer_done;
  state_t            state_dbg;

  logic [Pa-1:0] lane_val [4];
  int checks = 0;
  int errors = 0;

  relu_out_packer #(.Pa(Pa), .N_WORDS(N_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_in(relu_in), .sel(sel),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .word_idx(word_idx), .layer_done(layer_done), .state_dbg(state_dbg)
  );

  assign relu_in = lane_val[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3);
    lane_val[0] = v0; lane_val[1] = v1; lane_val[2] = v2; lane_val[3] = v3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_sel"},   32'(sel), 32'd0);
    check({tag, "_data"},  out_data, 32'h0);
    check({tag, "_idx"},   32'(word_idx), 32'd0);
    check({tag, "_done"},  32'(layer_done), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    set_lanes(8'h00, 8'h00, 8'h00, 8'h00);
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single word, ready high
    set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("w1_sel0", 32'(sel), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    check("w1_state_scan", 32'(state_dbg), 32'(ST_SCAN));
    tick(); check("w1_sel1", 32'(sel), 32'd1);
    tick(); check("w1_sel2", 32'(sel), 32'd2);
    tick(); check("w1_sel3", 32'(sel), 32'd3);
    check("w1_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_data", out_data, 32'h44332211);
    check("w1_idx", 32'(word_idx), 32'd0);
    tick();
    check("w1_acc_valid", 32'(out_valid), 32'd0);
    check("w1_acc_idx", 32'(word_idx), 32'd1);
    check("w1_acc_done", 32'(layer_done), 32'd0);
    check("w1_acc_state", 32'(state_dbg), 32'(ST_IDLE));

    // Backpressure plus start during SCAN at lane 2
    set_lanes(8'h55, 8'h66, 8'h77, 8'h88);
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("bp_sel2", 32'(sel), 32'd2);
    start = 1'b1; tick(); start = 1'b0;
    check("bp_sel3", 32'(sel), 32'd3);
    tick();
    check("bp_data", out_data, 32'h88776655);
    for (int i = 0; i < 10; i++) begin
      set_lanes(8'(i), 8'(i + 16), 8'hAA, 8'hBB);
      start = (i == 3);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'h88776655);
      check("bp_hold_idx", 32'(word_idx), 32'd1);
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_acc_valid", 32'(out_valid), 32'd0);
    check("bp_acc_idx_wrap", 32'(word_idx), 32'd0);
    check("bp_acc_done", 32'(layer_done), 32'd1);
    check("bp_acc_busy", 32'(busy), 32'd0);
    tick();
    check("bp_done_width", 32'(layer_done), 32'd0);
    check("bp_one_word", 32'(busy), 32'd0);

    // Back-to-back
    set_lanes(8'h01, 8'h02, 8'h03, 8'h04);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("b2b_w0_data", out_data, 32'h04030201);
    check("b2b_w0_valid", 32'(out_valid), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    check("b2b_rescan_busy", 32'(busy), 32'd1);
    check("b2b_rescan_valid", 32'(out_valid), 32'd0);
    check("b2b_rescan_sel", 32'(sel), 32'd0);
    check("b2b_idx1", 32'(word_idx), 32'd1);
    check("b2b_no_done", 32'(layer_done), 32'd0);
    set_lanes(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    tick(); tick(); tick();
    check("b2b_w1_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("b2b_w1_valid", 32'(out_valid), 32'd1);
    check("b2b_w1_data", out_data, 32'h0D0C0B0A);
    tick();
    check("b2b_done", 32'(layer_done), 32'd1);
    check("b2b_idx_wrap", 32'(word_idx), 32'd0);
    tick();
    check("b2b_done_drop", 32'(layer_done), 32'd0);

    // Reset during SCAN lane 1
    set_lanes(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("rs_scan_sel1", 32'(sel), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_reset_outputs("rst_scan");

    // Passthrough word, then reset during HOLD
    set_lanes(8'h00, 8'h7F, 8'h00, 8'h01);
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_data", out_data, 32'h01007F00);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_reset_outputs("rst_hold");

    // Fresh word after reset
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("fresh_valid", 32'(out_valid), 32'd1);
    check("fresh_data", out_data, 32'h01007F00);
    check("fresh_idx", 32'(word_idx), 32'd0);
    tick();
    check("fresh_acc_idx", 32'(word_idx), 32'd1);
    check("fresh_acc_done", 32'(layer_done), 32'd0);
    check("fresh_idle", 32'(state_dbg), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_out_packer.md
# relu_out_packer

Downstream sequencer and packer for the quantize/ReLU stage. After a start pulse from the accumulator controller, it steps the 2-bit lane select through lanes 0..3 and captures one ReLU'd Pa-bit value per cycle. It packs the four values into one 4·Pa-bit word and offers that word to the output/activation buffer over a valid/ready handshake. It also counts the words in a layer and pulses a done flag when the layer is complete.

## Interface
- Pa, 8, width of one quantized activation lane
- N_WORDS, 16, packed words per layer; must be at least 1
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  one-cycle request to scan the four quantized lanes
- relu_in  input  Pa  ReLU output for the lane currently selected by sel (combinational in sel)
- sel  output  2  lane select driven into the quantize/ReLU stage
- busy  output  1  high in SCAN and HOLD
- out_data  output  4·Pa  packed word; lane k occupies bits [k·Pa +: Pa]
- out_valid  output  1  out_data is stable and offered
- out_ready  input  1  downstream accepts the word
- word_idx  output  $clog2(N_WORDS) (min 1)  index of the word currently offered or next to be built
- layer_done  output  1  one-cycle pulse when word N_WORDS-1 is accepted

## Operation
- States are IDLE, SCAN and HOLD, with a 2-bit lane counter.
- **IDLE:**
  - sel=0, busy=0, out_valid=0.
  - start=1 moves to SCAN with lane=0.
- **SCAN:**
  - sel=lane. Each edge writes relu_in into the out_data slot for that lane.
  - When lane=3, the state moves to HOLD on the same edge. Otherwise lane increments.
  - start is ignored. There is no queuing.
- **HOLD:**
  - out_valid=1. out_data and word_idx stay stable until out_valid && out_ready.
  - On acceptance:
    - word_idx increments, wrapping from N_WORDS-1 to 0.
    - layer_done pulses if the accepted word was N_WORDS-1.
    - If start=1 in the same cycle, the state goes straight to SCAN with lane=0 (back-to-back). Otherwise it goes to IDLE.
  - start in HOLD without acceptance is ignored.
- out_data keeps its last value in IDLE. It is not cleared between words; every lane is overwritten during SCAN.
- There is no arithmetic on the data: relu_in is captured bit-exact, with no sign extension or saturation.
- **Reset (rst_n=0 on an edge, in any state, including mid-SCAN or mid-HOLD):**
  - state=IDLE, lane=0, sel=0, busy=0, out_valid=0, out_data=0, word_idx=0, layer_done=0.
  - A partially built word is discarded.

## Timing
- start is sampled high at edge E0.
- Scan cycles:
  - Cycle after E0: sel=0, captured at E1.
  - sel=1 is captured at E2, sel=2 at E3, sel=3 at E4.
- out_valid=1 from E4 (first cycle after E4).
- Latency from the start edge to valid is 4 cycles.
- With out_ready held high, the word is accepted at E5, and layer_done (if applicable) is high for the cycle after E5.
- Back-to-back throughput is one word per 5 cycles.
- sel is registered. relu_in must settle within the same cycle, because quant_ReLU is combinational.
- out_valid never drops without acceptance or reset. out_data does not change while out_valid=1.
- layer_done is registered and is exactly one cycle wide.

## Structure
- Shared package smac_relu_pkg holds:
  - the state enum (IDLE, SCAN, HOLD)
  - LANES = 4
  - SEL_W = 2
- The package is reused by the top level that wires sel to quant_ReLU.
- No sub-module is needed. relu_out_packer is instantiated beside quant_ReLU, with its sel output tied to quant_ReLU's sel input.
- Target size is about 150 lines of RTL: a single always_ff block for the state, lane, data and counter, plus combinational output decode.

## Test plan
- **Single word, ready held high:** relu_in model returns 8'h11/22/33/44 for sel 0..3; pulse start.
  - Expected: out_valid rises 4 cycles after the start edge with out_data=32'h44332211; the word is accepted next edge; word_idx goes 0→1; state returns to IDLE.
- **Backpressure:** hold out_ready=0 for 10 cycles while in HOLD; toggle relu_in and pulse start.
  - Expected: out_data, out_valid and word_idx stay stable; start is ignored; acceptance completes on the first out_ready=1 edge.
- **Back-to-back:** assert start in the acceptance cycle, with N_WORDS=2.
  - Expected: SCAN begins immediately; second word valid 4 cycles later; layer_done pulses once on its acceptance; word_idx wraps to 0.
- **start during SCAN:** pulse start at lane 2.
  - Expected: no effect; exactly one word is produced.
- **Reset mid-operation:** rst_n=0 for one edge during SCAN lane 1, and again during HOLD.
  - Expected: all outputs at reset values the next cycle; a fresh start yields a correct complete word.
- **Zero/negative passthrough:** relu_in = 8'h00, 8'h7F, 8'h00, 8'h01.
  - Expected: out_data=32'h01007F00, unmodified.
